// File: rtl/gtb_serial_ctrl.sv
// Sequenced Gray-to-binary converter: one input word is resolved MSB-first at one
// bit per clock through a single XOR, then held until the consumer takes it.
module gtb_serial_ctrl #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             busy,
  output logic [CNT_W-1:0] conv_count
);

  // Handshake: a word moves on any rising edge where valid and ready are both
  // high; valid never drops without ready, and data is stable while valid.
  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] g_reg;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_up;

  assign in_ready = (state == IDLE);
  assign idx_up   = idx + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      g_reg      <= '0;
      b_out      <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      conv_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            g_reg <= g_in;
            b_out <= {g_in[WIDTH-1], {(WIDTH-1){1'b0}}};
            idx   <= IDX_W'(WIDTH - 2);
            busy  <= 1'b1;
            state <= CONV;
          end
        end
        CONV: begin
          // Each edge resolves one bit from the already-resolved bit above it.
          b_out[idx] <= b_out[idx_up] ^ g_reg[idx];
          if (idx == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            conv_count <= conv_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gtb_serial_ctrl.sv
// Randomized bench for gtb_serial_ctrl against a shift-XOR Gray-to-binary model.
module tb_gtb_serial_ctrl;

  localparam int W  = 3;
  localparam int W8 = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [W-1:0] g_in = '0, b_out;
  logic [7:0]   conv_count;

  logic          in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, busy8;
  logic [W8-1:0] g_in8 = '0, b_out8;
  logic [7:0]    conv_count8;

  gtb_serial_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .g_in(g_in),
    .out_valid(out_valid), .out_ready(out_ready), .b_out(b_out), .busy(busy),
    .conv_count(conv_count)
  );

  gtb_serial_ctrl #(.WIDTH(W8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .g_in(g_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .b_out(b_out8), .busy(busy8),
    .conv_count(conv_count8)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // binary = XOR of the Gray word with every right-shifted copy of itself
  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int s = 0; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  // driver tasks
  task automatic convert(input logic [W-1:0] g, input logic [W-1:0] exp, input int bp,
                         input bit keep_valid);
    int lat;
    logic [W-1:0] e;
    check("in_ready_idle", {31'b0, in_ready}, 1);
    in_valid  = 1'b1;
    g_in      = g;
    out_ready = 1'($urandom_range(0, 1));
    exp_q.push_back(exp);
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    g_in = W'($urandom);
    lat  = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_conv", {31'b0, in_ready}, 0);
      check("busy_conv", {31'b0, busy}, 1);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, W - 1);
    e = exp_q.pop_front();
    if (bp > 0) out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      check("bp_out_valid", {31'b0, out_valid}, 1);
      check("bp_b_out", {29'b0, b_out}, {29'b0, e});
      check("bp_in_ready", {31'b0, in_ready}, 0);
      check("bp_busy", {31'b0, busy}, 1);
      g_in = W'($urandom);
      @(negedge clk);
    end
    check("b_out", {29'b0, b_out}, {29'b0, e});
    out_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("post_out_valid", {31'b0, out_valid}, 0);
    check("post_busy", {31'b0, busy}, 0);
    check("post_in_ready", {31'b0, in_ready}, 1);
    check("post_b_out_held", {29'b0, b_out}, {29'b0, e});
    check("conv_count", {24'b0, conv_count}, exp_cnt % 256);
    in_valid  = 1'b0;
    out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic run8(input logic [W8-1:0] g, input logic [W8-1:0] exp);
    int lat;
    in_valid8 = 1'b1;
    g_in8     = g;
    @(negedge clk);
    in_valid8 = 1'b0;
    g_in8     = W8'($urandom);
    lat = 0;
    while (!out_valid8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("w8_latency", lat, W8 - 1);
    check("w8_b_out", {24'b0, b_out8}, {24'b0, exp});
    out_ready8 = 1'b1;
    @(negedge clk);
    check("w8_done", {31'b0, out_valid8}, 0);
    out_ready8 = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    check({tag, "_busy"}, {31'b0, busy}, 0);
    check({tag, "_b_out"}, {29'b0, b_out}, 0);
    check({tag, "_conv_count"}, {24'b0, conv_count}, 0);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 1);
  endtask

  logic [W-1:0] sweep_exp [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                  3'b111, 3'b110, 3'b100, 3'b101};

  initial begin
    logic [W-1:0]  g;
    logic [W8-1:0] g8;
    // reset holds everything and blocks capture even with in_valid high
    in_valid = 1'b1;
    g_in     = 3'b111;
    @(negedge clk);
    @(negedge clk);
    reset_checks("rst");
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);

    convert(3'b110, 3'b100, 0, 0);
    for (int i = 0; i < 8; i++) convert(W'(i), sweep_exp[i], 0, 0);
    convert(3'b101, 3'b110, 5, 0);

    // asynchronous reset one edge into CONV
    in_valid = 1'b1;
    g_in     = 3'b111;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 reset_checks("rst_conv");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    convert(3'b011, 3'b010, 0, 0);

    // asynchronous reset while holding a result in DONE
    in_valid  = 1'b1;
    out_ready = 1'b0;
    g_in      = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("done_before_rst", {31'b0, out_valid}, 1);
    #1 rst = 1'b1;
    #1 reset_checks("rst_done");
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      g = W'($urandom);
      convert(g, W'(g2b({29'b0, g})), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    run8(8'hFF, 8'hAA);
    run8(8'h80, 8'hFF);
    for (int i = 0; i < 10; i++) begin
      g8 = W8'($urandom);
      run8(g8, W8'(g2b({24'b0, g8})));
    end

    // counter wrap with in_valid held through CONV/DONE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      g = W'($urandom);
      convert(g, W'(g2b({29'b0, g})), 0, 1'b1);
    end
    check("wrap_zero", {24'b0, conv_count}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
